// File: rtl/lpif_tx_ingress.sv
// LPIF TX ingress: beat FIFO toward the MAC framer, with an optional TLP
// framing checker compiled in when LPIF_TX_FRAME_CHECK_EN is defined.
module lpif_tx_ingress #(
    parameter int         DEPTH      = 4,
    parameter logic [3:0] ACTIVE_STS = 4'h1
) (
    input  logic                     CLK,
    input  logic                     lpreset,
    input  logic [3:0]               pl_state_sts,
    input  logic                     lp_irdy,
    input  logic [511:0]             lp_data,
    input  logic [63:0]              lp_valid,
    input  logic [63:0]              lp_tlpstart,
    input  logic [63:0]              lp_tlpend,
    input  logic [63:0]              lp_dlpstart,
    input  logic [63:0]              lp_dlpend,
    output logic                     pl_trdy,
    output logic                     tx_vld,
    input  logic                     tx_rdy,
    output logic [511:0]             tx_data,
    output logic [63:0]              tx_valid,
    output logic [63:0]              tx_tlpstart,
    output logic [63:0]              tx_tlpend,
    output logic [63:0]              tx_dlpstart,
    output logic [63:0]              tx_dlpend,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_framing,
    output logic                     tlp_open
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  valid;
        logic [63:0]  tlpstart;
        logic [63:0]  tlpend;
        logic [63:0]  dlpstart;
        logic [63:0]  dlpend;
    } beat_t;

    beat_t         mem [DEPTH];
    beat_t         in_beat;
    beat_t         head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          accept;
    logic          wr_en;
    logic          rd_en;

    assign in_beat = {lp_data, lp_valid, lp_tlpstart,
                      lp_tlpend, lp_dlpstart, lp_dlpend};

    // Ready depends only on the occupancy register and link state.
    assign pl_trdy = !lpreset
                   && (level_q != LW'(DEPTH))
                   && (pl_state_sts == ACTIVE_STS);

    assign accept = lp_irdy && pl_trdy;
    assign wr_en  = accept && (|lp_valid);
    assign tx_vld = (level_q != '0);
    assign rd_en  = tx_vld && tx_rdy;
    assign level  = level_q;

    always_ff @(posedge CLK or posedge lpreset) begin
        if (lpreset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset; the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= in_beat;
    end

    assign head        = mem[rd_ptr];
    assign tx_data     = tx_vld ? head.data     : '0;
    assign tx_valid    = tx_vld ? head.valid    : '0;
    assign tx_tlpstart = tx_vld ? head.tlpstart : '0;
    assign tx_tlpend   = tx_vld ? head.tlpend   : '0;
    assign tx_dlpstart = tx_vld ? head.dlpstart : '0;
    assign tx_dlpend   = tx_vld ? head.dlpend   : '0;

`ifdef LPIF_TX_FRAME_CHECK_EN
    logic scan_err;
    logic scan_open;

    // Walk bytes low to high, carrying the open/closed TLP state along.
    always_comb begin
        scan_err  = 1'b0;
        scan_open = tlp_open;
        for (int i = 0; i < 64; i++) begin
            if ((lp_tlpstart[i] || lp_tlpend[i] ||
                 lp_dlpstart[i] || lp_dlpend[i]) && !lp_valid[i])
                scan_err = 1'b1;
            if (lp_tlpstart[i] && lp_tlpend[i])
                scan_err = 1'b1;
            if (lp_tlpstart[i] && scan_open)
                scan_err = 1'b1;
            if (lp_tlpend[i] && !scan_open)
                scan_err = 1'b1;
            scan_open = (scan_open || lp_tlpstart[i]) && !lp_tlpend[i];
        end
    end

    always_ff @(posedge CLK or posedge lpreset) begin
        if (lpreset) begin
            err_framing <= 1'b0;
            tlp_open    <= 1'b0;
        end else begin
            err_framing <= accept && scan_err;
            if (accept)
                tlp_open <= scan_open;
        end
    end
`else
    assign err_framing = 1'b0;
    assign tlp_open    = 1'b0;
`endif

endmodule

// File: tb/tb_lpif_tx_ingress.sv
// Directed + randomized bench for lpif_tx_ingress against a queue model.
module tb_lpif_tx_ingress;

`ifdef LPIF_TX_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic         CLK;
    logic         lpreset;
    logic [3:0]   pl_state_sts;
    logic         lp_irdy;
    logic [511:0] lp_data;
    logic [63:0]  lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;
    logic         pl_trdy, tx_vld, tx_rdy;
    logic [511:0] tx_data;
    logic [63:0]  tx_valid, tx_tlpstart, tx_tlpend, tx_dlpstart, tx_dlpend;
    logic [2:0]   level;
    logic         err_framing, tlp_open;

    lpif_tx_ingress #(.DEPTH(DEPTH), .ACTIVE_STS(4'h1)) dut (
        .CLK(CLK), .lpreset(lpreset), .pl_state_sts(pl_state_sts),
        .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid),
        .lp_tlpstart(lp_tlpstart), .lp_tlpend(lp_tlpend),
        .lp_dlpstart(lp_dlpstart), .lp_dlpend(lp_dlpend),
        .pl_trdy(pl_trdy), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_tlpstart(tx_tlpstart), .tx_tlpend(tx_tlpend),
        .tx_dlpstart(tx_dlpstart), .tx_dlpend(tx_dlpend),
        .level(level), .err_framing(err_framing), .tlp_open(tlp_open)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [511:0] d;
        logic [63:0]  v, ts, te, ds, de;
    } beat_t;

    beat_t q[$];
    bit    m_open, m_err;
    int    total, bad;

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_trdy();
        return !lpreset && q.size() != DEPTH && pl_state_sts == 4'h1;
    endfunction

    // Framing rules applied byte by byte from the starting open state.
    function automatic void scan(input beat_t b, input bit open_in,
                                 output bit err, output bit open_out);
        bit o = open_in;
        err = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bit s = b.ts[i], e = b.te[i];
            bit any = s | e | b.ds[i] | b.de[i];
            if (any && !b.v[i]) err = 1'b1;
            if (s && e) err = 1'b1;
            if (s && o) err = 1'b1;
            if (e && !o) err = 1'b1;
            if (e) o = 1'b0;
            else if (s) o = 1'b1;
        end
        open_out = o;
    endfunction

    function automatic beat_t plain_beat();
        beat_t b;
        for (int i = 0; i < 16; i++) b.d[32*i +: 32] = $urandom;
        b.v = '1; b.ts = '0; b.te = '0; b.ds = '0; b.de = '0;
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b = plain_beat();
        b.v = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) b.v = '0;
        else if ($urandom_range(0, 3) == 0) b.v = '1;
        for (int i = 0; i < 64; i++) begin
            b.ts[i] = ($urandom_range(0, 79) == 0);
            b.te[i] = ($urandom_range(0, 79) == 0);
            b.ds[i] = ($urandom_range(0, 99) == 0);
            b.de[i] = ($urandom_range(0, 99) == 0);
        end
        return b;
    endfunction

    task automatic drive(input beat_t b);
        lp_data = b.d; lp_valid = b.v;
        lp_tlpstart = b.ts; lp_tlpend = b.te;
        lp_dlpstart = b.ds; lp_dlpend = b.de;
    endtask

    task automatic check_all();
        beat_t h;
        h.d = '0; h.v = '0; h.ts = '0; h.te = '0; h.ds = '0; h.de = '0;
        if (q.size() != 0) h = q[0];
        chk("level", 512'(level), 512'(q.size()));
        chk("tx_vld", 512'(tx_vld), 512'(q.size() != 0));
        chk("tx_data", tx_data, h.d);
        chk("tx_valid", 512'(tx_valid), 512'(h.v));
        chk("tx_tlpstart", 512'(tx_tlpstart), 512'(h.ts));
        chk("tx_tlpend", 512'(tx_tlpend), 512'(h.te));
        chk("tx_dlpstart", 512'(tx_dlpstart), 512'(h.ds));
        chk("tx_dlpend", 512'(tx_dlpend), 512'(h.de));
        chk("err_framing", 512'(err_framing), 512'(m_err));
        chk("tlp_open", 512'(tlp_open), 512'(m_open));
    endtask

    task automatic cycle();
        bit acc, pop, se, so;
        beat_t cur, tmp;
        #1;
        chk("pl_trdy", 512'(pl_trdy), 512'(exp_trdy()));
        acc = lp_irdy && exp_trdy();
        pop = (q.size() != 0) && tx_rdy;
        cur.d = lp_data; cur.v = lp_valid;
        cur.ts = lp_tlpstart; cur.te = lp_tlpend;
        cur.ds = lp_dlpstart; cur.de = lp_dlpend;
        scan(cur, m_open, se, so);
        @(posedge CLK);
        #1;
        if (pop) tmp = q.pop_front();
        if (acc && cur.v != '0) q.push_back(cur);
        m_err = acc && se && CHK;
        if (acc) m_open = so && CHK;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        m_open = 1'b0;
        m_err  = 1'b0;
    endtask

    initial begin
        beat_t b;
        total = 0; bad = 0;
        lpreset = 1'b1; pl_state_sts = 4'h1;
        lp_irdy = 1'b0; tx_rdy = 1'b0;
        drive(plain_beat());
        model_reset();
        #1;
        chk("reset_pl_trdy", 512'(pl_trdy), 512'(0));
        check_all();
        repeat (2) @(posedge CLK);
        #1 lpreset = 1'b0;

        // Five back-to-back beats into a stalled FIFO, then drain in order.
        lp_irdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(plain_beat());
            cycle();
        end
        chk("req032_level", 512'(level), 512'(4));
        chk("req032_trdy", 512'(pl_trdy), 512'(0));
        lp_irdy = 1'b0; tx_rdy = 1'b1;
        repeat (5) cycle();

        // Full FIFO with write and pop requested together.
        tx_rdy = 1'b0; lp_irdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(plain_beat());
            cycle();
        end
        drive(plain_beat());
        tx_rdy = 1'b1;
        cycle();
        chk("req033_level", 512'(level), 512'(3));
        lp_irdy = 1'b0;
        #1 chk("req033_trdy", 512'(pl_trdy), 512'(1));
        repeat (4) cycle();

        // Well-formed TLP, then a stray end.
        lp_irdy = 1'b1;
        b = plain_beat(); b.ts[0] = 1'b1; b.te[47] = 1'b1;
        drive(b);
        cycle();
        chk("req034_err0", 512'(err_framing), 512'(0));
        chk("req034_open0", 512'(tlp_open), 512'(0));
        b = plain_beat(); b.te[3] = 1'b1;
        drive(b);
        cycle();
        chk("req034_err1", 512'(err_framing), 512'(CHK));
        lp_irdy = 1'b0;
        repeat (3) cycle();

        // Empty beat discarded; marker on an invalid byte.
        lp_irdy = 1'b1;
        b = plain_beat(); b.v = '0;
        drive(b);
        cycle();
        chk("req035_level", 512'(level), 512'(0));
        chk("req035_vld", 512'(tx_vld), 512'(0));
        b = plain_beat(); b.v[10] = 1'b0; b.ds[10] = 1'b1;
        drive(b);
        cycle();
        chk("req035_err", 512'(err_framing), 512'(CHK));
        lp_irdy = 1'b0;
        repeat (3) cycle();

        // Link leaves Active with two beats stored.
        tx_rdy = 1'b0; lp_irdy = 1'b1;
        repeat (2) begin
            drive(plain_beat());
            cycle();
        end
        pl_state_sts = 4'h0;
        #1 chk("req036_trdy", 512'(pl_trdy), 512'(0));
        tx_rdy = 1'b1;
        repeat (3) cycle();
        chk("req036_level", 512'(level), 512'(0));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            pl_state_sts = ($urandom_range(0, 9) == 0) ?
                           4'($urandom_range(0, 15)) : 4'h1;
            lp_irdy = ($urandom_range(0, 3) != 0);
            tx_rdy  = ($urandom_range(0, 2) != 0);
            drive(rand_beat());
            cycle();
        end

        // Asynchronous reset with three beats stored and a TLP open.
        pl_state_sts = 4'h1; lp_irdy = 1'b0; tx_rdy = 1'b1;
        repeat (5) cycle();
        tx_rdy = 1'b0; lp_irdy = 1'b1;
        b = plain_beat(); b.ts[5] = 1'b1;
        drive(b);
        cycle();
        repeat (2) begin
            drive(plain_beat());
            cycle();
        end
        chk("req037_level_pre", 512'(level), 512'(3));
        chk("req037_open_pre", 512'(tlp_open), 512'(CHK));
        #1 lpreset = 1'b1;
        model_reset();
        #1;
        chk("req037_level", 512'(level), 512'(0));
        chk("req037_vld", 512'(tx_vld), 512'(0));
        chk("req037_open", 512'(tlp_open), 512'(0));
        chk("req037_trdy", 512'(pl_trdy), 512'(0));
        chk("req037_data", tx_data, 512'(0));
        @(posedge CLK);
        #1;
        check_all();
        lpreset = 1'b0;
        lp_irdy = 1'b0;
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
